// File: rtl/conv_viterbi_codec.sv
// conv_viterbi_codec
//
// Rate-1/2, K=3 convolutional encoder (generators 7 and 5) and a hard-decision Viterbi decoder
// that keeps its survivors by register exchange.
//
// Optional feature macro: CODEC_METRIC_ACC_EN adds the dec_metric_acc output, a saturating
// count of the channel errors seen along the best path.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   enc_enable_i   encoder accepts enc_d_in this cycle
//   enc_d_in       information bit
//   enc_valid_o    enc_d_out holds a new symbol
//   enc_d_out      coded symbol {g0 (7), g1 (5)}
//   dec_enable     decoder accepts dec_d_in this cycle
//   dec_d_in       received symbol {g0, g1}
//   dec_d_out      decoded bit, TB_DEPTH-1 enabled symbols behind the input
//   dec_metric_acc accumulated best-path metric (CODEC_METRIC_ACC_EN only)

module conv_viterbi_codec #(
  parameter int unsigned TB_DEPTH = 24,
  parameter int unsigned PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
`ifdef CODEC_METRIC_ACC_EN
  output logic [15:0] dec_metric_acc,
`endif
  output logic       dec_d_out
);

  // Expected symbol leaving state p = {s1, s2} on input u.
  function automatic logic [1:0] exp_sym(input logic [1:0] p, input logic u);
    return {u ^ p[1] ^ p[0], u ^ p[0]};
  endfunction

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] ham(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------------------------
  logic [1:0] enc_s_q, enc_s_d;
  logic [1:0] enc_out_q, enc_out_d;
  logic       enc_valid_q, enc_valid_d;

  always_comb begin
    enc_s_d     = enc_s_q;
    enc_out_d   = enc_out_q;
    enc_valid_d = enc_enable_i;
    if (enc_enable_i) begin
      enc_out_d = exp_sym(enc_s_q, enc_d_in);
      enc_s_d   = {enc_d_in, enc_s_q[1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_s_q     <= 2'b00;
      enc_out_q   <= 2'b00;
      enc_valid_q <= 1'b0;
    end else begin
      enc_s_q     <= enc_s_d;
      enc_out_q   <= enc_out_d;
      enc_valid_q <= enc_valid_d;
    end
  end

  assign enc_valid_o = enc_valid_q;
  assign enc_d_out   = enc_out_q;

  // ---------------------------------------------------------------------------------------------
  // Decoder: add-compare-select
  // ---------------------------------------------------------------------------------------------
  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic                dec_out_q, dec_out_d;

  logic [PM_W-1:0]     sum0   [4];
  logic [PM_W-1:0]     sum1   [4];
  logic [PM_W-1:0]     pm_new [4];
  logic [3:0]          sel;
  logic [PM_W-1:0]     min_pm;
  logic [1:0]          best;

  // Next state i = {u, s1} is reached from {s1, 0} (sum0) or {s1, 1} (sum1).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum0[i]   = pm_q[{i[0], 1'b0}] + PM_W'(ham(dec_d_in, exp_sym({i[0], 1'b0}, i[1])));
      sum1[i]   = pm_q[{i[0], 1'b1}] + PM_W'(ham(dec_d_in, exp_sym({i[0], 1'b1}, i[1])));
      // Strict compare: ties go to the s2 = 0 predecessor.
      sel[i]    = (sum1[i] < sum0[i]);
      pm_new[i] = sel[i] ? sum1[i] : sum0[i];
    end
    // Strict compare keeps the lowest index on ties.
    min_pm = pm_new[0];
    best   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_new[i] < min_pm) begin
        min_pm = pm_new[i];
        best   = 2'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pm_d[i]   = pm_q[i];
      surv_d[i] = surv_q[i];
    end
    dec_out_d = dec_out_q;
    if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        pm_d[i]   = pm_new[i] - min_pm;
        surv_d[i] = {surv_q[{i[0], sel[i]}][TB_DEPTH-2:0], i[1]};
      end
      dec_out_d = surv_d[best][TB_DEPTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Start pinned to state 0: the other states begin with a large handicap.
      pm_q[0] <= '0;
      for (int i = 1; i < 4; i++) pm_q[i] <= PM_W'(8);
      for (int i = 0; i < 4; i++) surv_q[i] <= '0;
      dec_out_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      dec_out_q <= dec_out_d;
    end
  end

  assign dec_d_out = dec_out_q;

`ifdef CODEC_METRIC_ACC_EN
  // Pre-normalisation minimum is the best path's metric increment for this symbol.
  logic [15:0] acc_q, acc_d;
  logic [16:0] acc_sum;

  always_comb begin
    acc_d   = acc_q;
    acc_sum = {1'b0, acc_q} + 17'(min_pm);
    if (dec_enable) begin
      acc_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign dec_metric_acc = acc_q;
`endif

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Self-checking bench for conv_viterbi_codec: encoder vector table, then loopback streams
// through a one-register channel with optional single-bit error injection.

module tb_conv_viterbi_codec;

  localparam int unsigned Lat = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable;
  logic [1:0] dec_d_in;
  logic       dec_d_out;
`ifdef CODEC_METRIC_ACC_EN
  logic [15:0] dec_metric_acc;
`endif

  int checks = 0;
  int errors = 0;

  conv_viterbi_codec dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
`ifdef CODEC_METRIC_ACC_EN
    .dec_metric_acc (dec_metric_acc),
`endif
    .dec_d_out    (dec_d_out)
  );

  always #5 clk = ~clk;

  // Channel: one register between encoder and decoder, with optional bit flips on every 16th
  // symbol of the first 256.
  logic       flip_en = 1'b0;
  logic [15:0] sym_cnt;
  logic [1:0]  ch_sym;
  logic        ch_en;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_sym  <= 2'b00;
      ch_en   <= 1'b0;
      sym_cnt <= '0;
    end else begin
      ch_en <= enc_valid_o;
      if (enc_valid_o) begin
        ch_sym  <= enc_d_out ^ ((flip_en && sym_cnt < 16'd256 && sym_cnt[3:0] == 4'd0) ?
                                2'b01 : 2'b00);
        sym_cnt <= sym_cnt + 16'd1;
      end
    end
  end

  assign dec_enable = ch_en;
  assign dec_d_in   = ch_sym;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of bits accepted by the encoder since the last reset.
  bit sent[$];
  int dec_cnt = 0;

  // Monitor: every enabled decoder edge yields the bit Lat symbols back (0 before that).
  always begin
    logic en;
    @(posedge clk);
    en = dec_enable;
    if (!rst) dec_cnt = 0;
    #1;
    if (rst && en) begin
      if (dec_cnt < Lat) chk("dec_prefix", 32'(dec_d_out), 32'd0);
      else               chk("dec_bit", 32'(dec_d_out), 32'(sent[dec_cnt - Lat]));
      dec_cnt++;
    end
  end

  task automatic send_bit(input bit b);
    @(negedge clk);
    enc_enable_i = 1'b1;
    enc_d_in     = b;
    sent.push_back(b);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      enc_enable_i = 1'b0;
    end
  endtask

  task automatic check_zero_outputs();
    chk("rst_enc_valid", 32'(enc_valid_o), 32'd0);
    chk("rst_enc_out", 32'(enc_d_out), 32'd0);
    chk("rst_dec_out", 32'(dec_d_out), 32'd0);
`ifdef CODEC_METRIC_ACC_EN
    chk("rst_metric_acc", 32'(dec_metric_acc), 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    sent.delete();
    #1;
    check_zero_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit       en;
    bit       u;
    bit       exp_valid;
    bit [1:0] exp_out;
  } enc_vec_t;

  enc_vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap_len;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 2'b11};  // impulse 1,0,0,0
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2'b10};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2'b11};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'b00};  // hold while disabled
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2'b11};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'b11};  // output and state hold
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b01};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 2'b10};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 2'b01};

    // Reset with random inputs.
    repeat (5) begin
      @(negedge clk);
      enc_enable_i = 1'($urandom_range(0, 1));
      enc_d_in     = 1'($urandom_range(0, 1));
      #1;
      check_zero_outputs();
    end
    @(negedge clk);
    enc_enable_i = 1'b0;
    rst          = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_enc_valid", 32'(enc_valid_o), 32'd0);
    end

    // Encoder vector table.
    foreach (vecs[i]) begin
      @(negedge clk);
      enc_enable_i = vecs[i].en;
      enc_d_in     = vecs[i].u;
      if (vecs[i].en) sent.push_back(vecs[i].u);
      @(posedge clk);
      #1;
      chk($sformatf("enc_valid[%0d]", i), 32'(enc_valid_o), 32'(vecs[i].exp_valid));
      chk($sformatf("enc_out[%0d]", i), 32'(enc_d_out), 32'(vecs[i].exp_out));
    end

    // Clean loopback.
    for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(0, 1)));
    idle(5);
    chk("clean_dec_count", 32'(dec_cnt), 32'(sent.size()));
`ifdef CODEC_METRIC_ACC_EN
    chk("clean_metric_acc", 32'(dec_metric_acc), 32'd0);
`endif

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
    do_reset();
    for (int i = 0; i < 150; i++) send_bit(1'($urandom_range(0, 1)));
    idle(5);
    chk("restart_dec_count", 32'(dec_cnt), 32'(sent.size()));

    // Sparse single-bit errors: 16 flips in the first 256 symbols.
    do_reset();
    flip_en = 1'b1;
    for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(0, 1)));
    idle(5);
    flip_en = 1'b0;
    chk("sparse_dec_count", 32'(dec_cnt), 32'(sent.size()));
`ifdef CODEC_METRIC_ACC_EN
    chk("sparse_metric_acc", 32'(dec_metric_acc), 32'd16);
`endif

    // Enable gaps.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        gap_len = int'($urandom_range(1, 5));
        idle(gap_len);
      end
    end
    idle(5);
    chk("gap_dec_count", 32'(dec_cnt), 32'(sent.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
